fifo_wr_ptr_ctrl: RTL and testbench
===================================

Name: fifo_wr_ptr_ctrl

Overview:
- Write-side pointer and flag controller for the FIFO.
- Counterpart of the read-side empty/occupancy logic: owns the write pointer, accepts or blocks writes, and produces registered full, almost_full, free-space and overflow status.
- Sits in the write clock domain.
- rd_addr arrives already synchronized and converted to binary.
- Produces both binary and Gray write pointers: Gray for crossing to the read domain, binary for the memory and the occupancy logic.

Parameters:
- DEEPWID, 3, log2 of FIFO depth; DEPTH = 2^DEEPWID; pointers are DEEPWID+1 bits (MSB = wrap bit).

Ports:
- clk  input  1  write-domain clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write request from producer
- rd_addr  input  DEEPWID+1  binary read pointer, already synchronized into clk domain
- cfg_almost_full  input  DEEPWID  almost_full threshold in free entries
- clr_ovf  input  1  clear sticky overflow
- mem_we  output  1  memory write strobe (combinational: wr_en & ~full)
- mem_waddr  output  DEEPWID  memory write address = wr_addr[DEEPWID-1:0]
- wr_addr  output  DEEPWID+1  registered binary write pointer
- wr_addr_gray  output  DEEPWID+1  registered Gray write pointer, for CDC to read domain
- full  output  1  registered full flag
- almost_full  output  1  registered, free_num <= cfg_almost_full
- free_num  output  DEEPWID+1  registered free entries, 0..DEPTH
- overflow  output  1  sticky, write attempted while full

Behaviour:
- Reset (rst_n low, async, immediate):
  - wr_addr = 0, wr_addr_gray = 0.
  - full = 0, almost_full = (DEPTH <= cfg_almost_full) evaluated after reset (0 for legal cfg).
  - free_num = DEPTH, overflow = 0.
- Reset mid-operation drops the pointer to 0 regardless of rd_addr. The read side must be reset concurrently; no other recovery is provided.
- Accept: wr_acc = wr_en & ~full. mem_we = wr_acc in the same cycle, and the data is written at mem_waddr = current wr_addr.
- Pointer update: wr_nxt = wr_addr + wr_acc, modulo 2^(DEEPWID+1), so the wrap bit toggles every DEPTH writes. wr_addr <= wr_nxt on each clk rising edge.
- Gray update: wr_addr_gray <= wr_nxt ^ (wr_nxt >> 1), registered from wr_nxt so that it is glitch-free and one bit changes per write.
- Occupancy: used = (wr_nxt - rd_addr) mod 2^(DEEPWID+1), computed with the rd_addr sampled this cycle.
  - full <= (used == DEPTH), i.e. MSBs differ and the lower DEEPWID bits are equal.
  - free_num <= DEPTH - used.
  - almost_full <= (DEPTH - used) <= cfg_almost_full.
- Flag latency:
  - A write that fills the FIFO asserts full on the next cycle, so a back-to-back write in that cycle is blocked.
  - A read-side pointer advance deasserts full / raises free_num one cycle after the rd_addr change is seen. This is conservative; full is never low while the FIFO is truly full.
- Simultaneous write and rd_addr advance: used stays equal; the flags are unchanged.
- Overflow: set when wr_en & full. Cleared by clr_ovf. If set and clear occur in the same cycle, set wins. The pointer never advances on a blocked write.
- rd_addr is trusted: used > DEPTH is illegal input. No checking; behaviour is then undefined.
- cfg_almost_full changes take effect on the next edge.

Test Plan:
- Reset with DEEPWID=3, rd_addr=0 -> wr_addr=0, gray=0, full=0, free_num=8, overflow=0.
- Eight consecutive wr_en with rd_addr=0:
  - mem_waddr steps 0..7.
  - Cycle after the 8th write: wr_addr=8 (4'b1000), gray=4'b1100, full=1, free_num=0.
  - A 9th wr_en -> mem_we=0, wr_addr stays 8, overflow=1.
- From full, set rd_addr=3 -> the next edge gives full=0, free_num=3. Three writes then give wr_addr=11, full=1.
- Wrap: drive rd_addr/wr_en through 20 writes with the FIFO kept at ~2 entries -> wr_addr wraps 15->0, gray sequence has single-bit changes, full never asserts.
- cfg_almost_full=2, fill from empty -> almost_full rises the cycle after the 6th write (free_num=2) and falls when rd_addr advances so that free_num=3.
- Overflow set with clr_ovf=1 in the same cycle -> overflow=1. Next cycle clr_ovf=1 and wr_en=0 -> overflow=0. Assert rst_n=0 while half full -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Owns the binary/Gray write pointer, gates writes while full and
// produces registered full, almost_full, free-space and sticky overflow.
// rd_addr is expected already synchronized and converted to binary.
module fifo_wr_ptr_ctrl #(
  parameter int DEEPWID = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [DEEPWID:0]   rd_addr,
  input  logic [DEEPWID-1:0] cfg_almost_full,
  input  logic               clr_ovf,
  output logic               mem_we,
  output logic [DEEPWID-1:0] mem_waddr,
  output logic [DEEPWID:0]   wr_addr,
  output logic [DEEPWID:0]   wr_addr_gray,
  output logic               full,
  output logic               almost_full,
  output logic [DEEPWID:0]   free_num,
  output logic               overflow
);

  localparam int DEPTH = 1 << DEEPWID;
  localparam logic [DEEPWID:0] DEPTH_V = DEPTH[DEEPWID:0];

  logic             wr_acc;
  logic [DEEPWID:0] wr_nxt;
  logic [DEEPWID:0] used;
  logic [DEEPWID:0] free_nxt;

  // Next pointer and occupancy as seen after this cycle's accepted write.
  // Modulo arithmetic on the wrap-bit-extended pointers gives 0..DEPTH.
  always_comb begin
    wr_acc   = wr_en & ~full;
    wr_nxt   = wr_addr + {{DEEPWID{1'b0}}, wr_acc};
    used     = wr_nxt - rd_addr;
    free_nxt = DEPTH_V - used;
  end

  assign mem_we    = wr_acc;
  assign mem_waddr = wr_addr[DEEPWID-1:0];

  // Binary and Gray pointers, both registered from the same next value so
  // the Gray copy changes exactly one bit per accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr      <= '0;
      wr_addr_gray <= '0;
    end else begin
      wr_addr      <= wr_nxt;
      wr_addr_gray <= wr_nxt ^ (wr_nxt >> 1);
    end
  end

  // Registered status flags; full is conservative in that a read advance
  // is only reflected one cycle after rd_addr changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full        <= 1'b0;
      almost_full <= 1'b0;
      free_num    <= DEPTH_V;
    end else begin
      full        <= (used == DEPTH_V);
      almost_full <= (free_nxt <= {1'b0, cfg_almost_full});
      free_num    <= free_nxt;
    end
  end

  // Sticky overflow: a blocked write attempt sets it, set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl with DEEPWID=3: a directed vector table for
// the fill / overflow / read-release corners, an async reset check, a wrap
// run and randomized traffic against a count-based reference model.
module tb_fifo_wr_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] rd_addr;
  logic [2:0] cfg_almost_full;
  logic       clr_ovf;
  logic       mem_we;
  logic [2:0] mem_waddr;
  logic [3:0] wr_addr;
  logic [3:0] wr_addr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] free_num;
  logic       overflow;

  fifo_wr_ptr_ctrl #(.DEEPWID(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_addr(rd_addr),
    .cfg_almost_full(cfg_almost_full), .clr_ovf(clr_ovf),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .wr_addr(wr_addr),
    .wr_addr_gray(wr_addr_gray), .full(full), .almost_full(almost_full),
    .free_num(free_num), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic       we;
    logic [3:0] rd;
    logic       clr;
    logic       mwe;
    logic [2:0] mwa;
    logic [3:0] wa;
    logic [3:0] g;
    logic       full;
    logic [3:0] free;
    logic       af;
    logic       ovf;
  } vec_t;

  vec_t tbl[18];

  // Reference model: total accepted writes and total reads as plain counts.
  int   m_wr, m_rd;
  bit   m_full, m_ovf;
  logic [3:0] prev_gray;

  function automatic logic [3:0] gray_of(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0; prev_gray = 4'd0;
  endtask

  // One cycle with model-based checking; new_rd is the cumulative read count.
  task automatic cycle(input bit we, input int new_rd, input int cfg, input bit clr);
    bit acc;
    int used, free_e;
    @(negedge clk);
    wr_en = we; clr_ovf = clr; cfg_almost_full = cfg[2:0];
    rd_addr = new_rd[3:0];
    #1;
    acc = we && !m_full;
    chk("mem_we", mem_we, acc);
    chk("mem_waddr", mem_waddr, m_wr % 8);
    m_ovf  = (we && m_full) || (m_ovf && !clr);
    m_wr   = m_wr + (acc ? 1 : 0);
    m_rd   = new_rd;
    used   = m_wr - m_rd;
    free_e = 8 - used;
    m_full = (used == 8);
    @(posedge clk); #1;
    chk("wr_addr", wr_addr, m_wr % 16);
    chk("wr_addr_gray", wr_addr_gray, gray_of(m_wr));
    chk("gray_step", $countones(wr_addr_gray ^ prev_gray), acc ? 1 : 0);
    chk("full", full, m_full);
    chk("free_num", free_num, free_e);
    chk("almost_full", almost_full, free_e <= cfg);
    chk("overflow", overflow, m_ovf);
    prev_gray = wr_addr_gray;
  endtask

  initial begin
    // Directed table, cfg_almost_full = 2 throughout.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1, 0, 0, 1, i[2:0], 4'(i + 1), gray_of(i + 1),
                 (i == 7), 4'(7 - i), (i >= 5), 0};
    tbl[8]  = '{1, 0, 0, 0, 0, 8, 4'b1100, 1, 0, 1, 1};
    tbl[9]  = '{1, 0, 1, 0, 0, 8, 4'b1100, 1, 0, 1, 1};
    tbl[10] = '{0, 0, 1, 0, 0, 8, 4'b1100, 1, 0, 1, 0};
    tbl[11] = '{0, 3, 0, 0, 0, 8, 4'b1100, 0, 3, 0, 0};
    tbl[12] = '{1, 3, 0, 1, 0, 9, 13, 0, 2, 1, 0};
    tbl[13] = '{1, 3, 0, 1, 1, 10, 15, 0, 1, 1, 0};
    tbl[14] = '{1, 3, 0, 1, 2, 11, 14, 1, 0, 1, 0};
    tbl[15] = '{0, 5, 0, 0, 3, 11, 14, 0, 2, 1, 0};
    tbl[16] = '{1, 6, 0, 1, 3, 12, 10, 0, 2, 1, 0};
    tbl[17] = '{1, 7, 0, 1, 4, 13, 11, 0, 2, 1, 0};

    rst_n = 1'b0; wr_en = 0; rd_addr = 0; cfg_almost_full = 3'd2; clr_ovf = 0;
    #12;
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_gray", wr_addr_gray, 0);
    chk("rst_full", full, 0);
    chk("rst_free", free_num, 8);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr_en = tbl[i].we; rd_addr = tbl[i].rd; clr_ovf = tbl[i].clr;
      #1;
      chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].mwe);
      chk($sformatf("v%0d_mem_waddr", i), mem_waddr, tbl[i].mwa);
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_addr", i), wr_addr, tbl[i].wa);
      chk($sformatf("v%0d_gray", i), wr_addr_gray, tbl[i].g);
      chk($sformatf("v%0d_full", i), full, tbl[i].full);
      chk($sformatf("v%0d_free", i), free_num, tbl[i].free);
      chk($sformatf("v%0d_af", i), almost_full, tbl[i].af);
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].ovf);
    end

    // Async reset while 6 entries are held: must act without a clock edge.
    @(negedge clk); wr_en = 0; #1 rst_n = 1'b0; #1;
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_gray", wr_addr_gray, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_free", free_num, 8);
    chk("mid_rst_af", almost_full, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    rd_addr = 0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();

    // Wrap run: 20 writes with the reader trailing by two entries.
    for (int i = 0; i < 20; i++) begin
      cycle(1, (m_wr >= 2) ? m_wr - 2 : 0, 2, 0);
      chk("wrap_no_full", full, 0);
    end
    chk("wrap_count", m_wr, 20);

    // Randomized traffic with a legal, occasionally stalling reader.
    for (int i = 0; i < 400; i++) begin
      int nrd;
      nrd = m_rd;
      if ($urandom_range(0, 2) == 0) nrd = m_rd + $urandom_range(0, m_wr - m_rd);
      cycle($urandom_range(0, 3) != 0, nrd, $urandom_range(0, 7),
            $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
